// File: rtl/lzx_prio_irq_ctrl.sv
// Eight-input priority interrupt controller. Falling edges on the request lines
// are latched as pending, and the highest unmasked pending request is granted.
module lzx_prio_irq_ctrl #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_n,
   input  logic       en_n,
   input  logic       mask_we,
   input  logic [7:0] mask_din,
   input  logic       ack,
   output logic       irq,
   output logic [2:0] vec,
   output logic [2:0] vec_n,
   output logic [7:0] pend,
   output logic       timeout,
   output logic       EO_n
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT   = 2'd1;
   localparam logic [1:0] RECOVER = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [7:0]    req_d_reg;
   logic [7:0]    pend_reg, pend_next;
   logic [7:0]    mask_reg, mask_next;
   logic [2:0]    vec_reg, vec_next;
   logic [CW-1:0] cnt_reg, cnt_next;

   logic [7:0]    capture;
   logic [7:0]    eligible;
   logic [2:0]    hi_idx;
   logic          hi_valid;
   logic          expire;

   // A capture is a high-to-low transition seen while the controller is enabled.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_capture
         assign capture[gi] = req_d_reg[gi] & ~req_n[gi] & ~en_n;
      end
   endgenerate

   assign eligible = pend_reg & ~mask_reg;
   assign hi_valid = |eligible;

   // Ascending scan so the highest set index is the one left standing.
   always_comb begin
      hi_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (eligible[i]) begin
            hi_idx = i[2:0];
         end
      end
   end

   assign expire = (state_reg == GRANT) && !ack && (cnt_reg == CW'(ACK_TIMEOUT - 1));

   always_comb begin
      state_next = state_reg;
      vec_next   = vec_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg | capture;
      mask_next  = mask_we ? mask_din : mask_reg;
      case (state_reg)
         IDLE: begin
            if (!en_n && hi_valid) begin
               state_next = GRANT;
               vec_next   = hi_idx;
               cnt_next   = '0;
            end
         end
         GRANT: begin
            if (ack) begin
               state_next = RECOVER;
               // A fresh edge on the granted line in the same cycle keeps it pending.
               pend_next[vec_reg] = capture[vec_reg];
            end else if (expire) begin
               state_next = RECOVER;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RECOVER: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         req_d_reg <= 8'hFF;
         pend_reg  <= 8'h00;
         mask_reg  <= 8'h00;
         vec_reg   <= 3'd0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         req_d_reg <= req_n;
         pend_reg  <= pend_next;
         mask_reg  <= mask_next;
         vec_reg   <= vec_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Outputs decode straight from state so reset drops irq without waiting for a clock.
   assign irq     = (state_reg == GRANT);
   assign vec     = irq ? vec_reg : 3'd0;
   assign vec_n   = ~vec;
   assign pend    = pend_reg;
   assign timeout = expire;
   assign EO_n    = ~(!en_n && (state_reg == IDLE) && !hi_valid);

endmodule

// File: tb/tb_lzx_prio_irq_ctrl.sv
// Directed scenarios followed by random traffic, all checked against a
// behavioural model of pending bits, the active grant and its age.
module tb_lzx_prio_irq_ctrl;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_n;
   logic       en_n;
   logic       mask_we;
   logic [7:0] mask_din;
   logic       ack;
   logic       irq;
   logic [2:0] vec;
   logic [2:0] vec_n;
   logic [7:0] pend;
   logic       timeout;
   logic       EO_n;

   int total = 0;
   int bad   = 0;

   // model state
   logic [7:0] m_pend, m_mask, m_prev;
   bit         m_granted, m_cool;
   int         m_idx, m_age;

   lzx_prio_irq_ctrl #(.ACK_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .req_n(req_n), .en_n(en_n), .mask_we(mask_we),
      .mask_din(mask_din), .ack(ack), .irq(irq), .vec(vec), .vec_n(vec_n),
      .pend(pend), .timeout(timeout), .EO_n(EO_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int top_bit(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'hFF;
      m_granted = 0; m_cool = 0; m_idx = 0; m_age = 0;
   endtask

   task automatic model_check();
      logic [2:0] ev;
      logic       et, eeo;
      ev  = m_granted ? 3'(m_idx) : 3'd0;
      et  = m_granted && (m_age == T - 1) && !ack;
      eeo = !(!en_n && !m_granted && !m_cool && ((m_pend & ~m_mask) == 8'h00));
      chk("m_irq", {7'd0, irq}, {7'd0, m_granted});
      chk("m_vec", {5'd0, vec}, {5'd0, ev});
      chk("m_vec_n", {5'd0, vec_n}, {5'd0, ~ev});
      chk("m_pend", pend, m_pend);
      chk("m_timeout", {7'd0, timeout}, {7'd0, et});
      chk("m_EO_n", {7'd0, EO_n}, {7'd0, eeo});
   endtask

   task automatic model_step();
      logic [7:0] fell, newp;
      int         h;
      fell = en_n ? 8'h00 : (m_prev & ~req_n);
      newp = m_pend | fell;
      if (m_granted) begin
         if (ack) begin
            if (!fell[m_idx]) newp[m_idx] = 1'b0;
            m_granted = 0; m_cool = 1;
         end else if (m_age == T - 1) begin
            m_granted = 0; m_cool = 1;
         end else begin
            m_age++;
         end
      end else if (m_cool) begin
         m_cool = 0;
      end else begin
         h = top_bit(m_pend & ~m_mask);
         if (!en_n && h >= 0) begin
            m_granted = 1; m_idx = h; m_age = 0;
         end
      end
      m_pend = newp;
      if (mask_we) m_mask = mask_din;
      m_prev = req_n;
   endtask

   // Called at edge+1 with inputs already set; returns at the next edge+1.
   task automatic cyc();
      #1;
      model_check();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_n = 8'hFF; en_n = 1'b0; ack = 1'b0;
      mask_we = 1'b0; mask_din = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      do_reset();
      chk("rst_pend", pend, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      chk("rst_vec", {5'd0, vec}, 8'h00);
      chk("rst_vec_n", {5'd0, vec_n}, 8'h07);
      chk("rst_timeout", {7'd0, timeout}, 8'h00);

      // priority
      req_n = 8'h5A; cyc();
      chk("prio_pend", pend, 8'hA5);
      cyc();
      chk("prio_vec", {5'd0, vec}, 8'h07);
      chk("prio_vec_n", {5'd0, vec_n}, 8'h00);
      ack = 1'b1; cyc();
      chk("prio_ack_pend", pend, 8'h25);
      ack = 1'b0; cyc(); cyc();
      chk("prio_next_vec", {5'd0, vec}, 8'h05);

      // latency and ack
      do_reset();
      req_n = 8'hF7; cyc();
      chk("lat_pend", pend, 8'h08);
      chk("lat_irq_k", {7'd0, irq}, 8'h00);
      cyc();
      chk("lat_irq_k1", {7'd0, irq}, 8'h01);
      chk("lat_vec", {5'd0, vec}, 8'h03);
      cyc();
      ack = 1'b1; cyc();
      chk("ack_irq", {7'd0, irq}, 8'h00);
      chk("ack_pend", pend, 8'h00);
      ack = 1'b0;
      chk("rec_EO_n", {7'd0, EO_n}, 8'h01);
      cyc();
      chk("idle_EO_n", {7'd0, EO_n}, 8'h00);

      // timeout
      do_reset();
      req_n = 8'hFB; cyc(); cyc();
      chk("to_grant", {5'd0, vec}, 8'h02);
      cyc(); cyc(); cyc();
      chk("to_pulse", {7'd0, timeout}, 8'h01);
      cyc();
      chk("to_rec_irq", {7'd0, irq}, 8'h00);
      chk("to_pend", pend, 8'h04);
      cyc(); cyc();
      chk("to_regrant", {6'd0, irq, vec == 3'd2}, 8'h03);

      // mask
      do_reset();
      mask_we = 1'b1; mask_din = 8'h80; cyc();
      mask_we = 1'b0; req_n = 8'h7E; cyc();
      chk("mask_pend", pend, 8'h81);
      cyc();
      chk("mask_vec0", {6'd0, irq, vec == 3'd0}, 8'h03);
      ack = 1'b1; cyc();
      ack = 1'b0; cyc();
      chk("mask_hold", pend, 8'h80);
      mask_we = 1'b1; mask_din = 8'h00; cyc();
      mask_we = 1'b0; cyc();
      chk("mask_vec7", {5'd0, vec}, 8'h07);

      // simultaneous ack and new edge on the granted bit
      do_reset();
      req_n = 8'hEF; cyc(); cyc();
      chk("sim_vec", {5'd0, vec}, 8'h04);
      req_n = 8'hFF; cyc();
      req_n = 8'hEF; ack = 1'b1; cyc();
      chk("sim_pend", pend, 8'h10);
      ack = 1'b0; cyc(); cyc();
      chk("sim_regrant", {6'd0, irq, vec == 3'd4}, 8'h03);

      // reset mid-grant, observed before any clock edge
      rst = 1'b1;
      #1;
      chk("mid_irq", {7'd0, irq}, 8'h00);
      chk("mid_vec", {5'd0, vec}, 8'h00);
      chk("mid_vec_n", {5'd0, vec_n}, 8'h07);
      chk("mid_pend", pend, 8'h00);
      chk("mid_timeout", {7'd0, timeout}, 8'h00);
      @(posedge clk);
      #1;
      do_reset();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         req_n    = req_n ^ 8'($urandom & $urandom & $urandom);
         ack      = ($urandom_range(0, 3) == 0);
         en_n     = ($urandom_range(0, 7) == 0);
         mask_we  = ($urandom_range(0, 15) == 0);
         mask_din = 8'($urandom & $urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
